// File: rtl/serial_transmitter_if.sv
// Byte-source / transmitter handshake bundle, plus the serial line and its debug index.
// The master side is the byte source; the slave side is serial_transmitter.
interface serial_transmitter_if;
  logic [7:0] data_in;
  logic       send;
  logic       ready;
  logic       done;
  logic       tx_out;
  logic [2:0] bit_index;

  modport master (output data_in, send, input ready, done, tx_out, bit_index);
  modport slave  (input data_in, send, output ready, done, tx_out, bit_index);
endinterface

// File: rtl/serial_transmitter.sv
// UART-style byte framer: start 0, 8 data bits LSB first, optional even parity, stop 1.
// Optional feature macro: PARITY_EN (inserts the parity bit; 11-bit frames).
//
// The last cycle of the stop bit is presented as IDLE with ready=1 and done=1, so a
// send accepted on that edge starts the next start bit immediately after a full
// CLKS_PER_BIT stop period; done pulses exactly one frame length apart back-to-back.
module serial_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_transmitter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic             bit_end;
  logic             stop_end;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       idx_inc;

  assign bit_end  = (cnt_q == BIT_LAST);
  assign stop_end = (cnt_q == STOP_LAST);
  assign cnt_inc  = cnt_q + 1'b1;
  assign idx_inc  = idx_q + 3'd1;

  // Next-state and next-output logic; every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        idx_d   = 3'd0;
        cnt_d   = '0;
        if (bus.send) begin
          byte_d  = bus.data_in;
          state_d = S_START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
          idx_d   = 3'd0;
          tx_d    = byte_q[0];
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
`ifdef PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^byte_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_inc;
            tx_d  = byte_q[idx_inc];
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        // The final stop cycle is spent in IDLE so a new send can land on its edge.
        if (stop_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  // State register; reset wins over everything, abandoning any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      byte_q  <= 8'hFF;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_out    = tx_q;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.bit_index = idx_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: a frame-level model predicts every cycle of the line,
// and a line decoder scores each completed frame against the byte queued at acceptance.
module tb_serial_transmitter;

  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  typedef struct packed {
    logic       tx;
    logic       ready;
    logic       done;
    logic [2:0] bi;
  } obs_t;

  localparam obs_t IDLE_OBS = '{tx: 1'b1, ready: 1'b1, done: 1'b0, bi: 3'd0};

  logic clock;
  logic reset;
  serial_transmitter_if bus ();

  serial_transmitter #(.CLKS_PER_BIT(CPB), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   armed  = 0;
  bit   rst_edge = 0;
  obs_t exp_o  = IDLE_OBS;
  obs_t exp_q[$];
  logic [7:0] byte_q[$];
  int   done_cyc[$];

  // Reference model: on each edge decide acceptance from the model's own ready,
  // then expand the accepted byte into its per-cycle line picture.
  initial forever begin
    @(posedge clock);
    cyc++;
    rst_edge = reset;
    if (reset) begin
      armed = 1;
      exp_q.delete();
      byte_q.delete();
      exp_o = IDLE_OBS;
    end else if (exp_o.ready && bus.send) begin
      logic [7:0] d;
      logic bits[$];
      obs_t o;
      d = bus.data_in;
      bits.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef PARITY_EN
      bits.push_back(^d);
`endif
      bits.push_back(1'b1);
      exp_q.delete();
      for (int b = 0; b < NBITS; b++) begin
        for (int c = 0; c < CPB; c++) begin
          o.tx    = bits[b];
          o.bi    = (b >= 1 && b <= 8) ? 3'(b - 1) : 3'd0;
          o.ready = (b == NBITS - 1) && (c == CPB - 1);
          o.done  = o.ready;
          exp_q.push_back(o);
        end
      end
      byte_q.push_back(d);
      exp_o = exp_q.pop_front();
    end else if (exp_q.size() > 0) begin
      exp_o = exp_q.pop_front();
    end else begin
      exp_o = IDLE_OBS;
    end
  end

  // Monitor: cycle-by-cycle line check plus a UART-style decoder scored on done.
  bit         dec_busy = 0;
  int         dec_c    = 0;
  logic [7:0] dec_byte;
  logic       dec_par;
  initial forever begin
    obs_t got;
    @(negedge clock);
    if (armed) begin
      got = '{tx: bus.tx_out, ready: bus.ready, done: bus.done, bi: bus.bit_index};
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL line_cycle cyc=%0d got tx=%b ready=%b done=%b idx=%0d, want tx=%b ready=%b done=%b idx=%0d",
                 cyc, got.tx, got.ready, got.done, got.bi, exp_o.tx, exp_o.ready, exp_o.done, exp_o.bi);
      end
      if (rst_edge) begin
        dec_busy = 0;
      end else begin
        if (!dec_busy && bus.tx_out === 1'b0) begin
          dec_busy = 1;
          dec_c    = 0;
          dec_byte = 8'h00;
          dec_par  = 1'b0;
        end else if (dec_busy) begin
          dec_c++;
        end
        if (dec_busy) begin
          for (int k = 1; k <= 9; k++) begin
            if (dec_c == k * CPB + CPB / 2) begin
              if (k <= 8) dec_byte[k-1] = bus.tx_out;
              else        dec_par       = bus.tx_out;
            end
          end
        end
        if (bus.done === 1'b1) begin
          done_cyc.push_back(cyc);
          checks++;
          if (byte_q.size() == 0) begin
            errors++;
            $display("FAIL frame_byte cyc=%0d got done with no frame pending, want no done", cyc);
          end else begin
            logic [7:0] want;
            want = byte_q.pop_front();
            if (!dec_busy || dec_byte !== want) begin
              errors++;
              $display("FAIL frame_byte cyc=%0d got %02h (decoding=%0b), want %02h", cyc, dec_byte, dec_busy, want);
            end
`ifdef PARITY_EN
            checks++;
            if (dec_par !== ^want) begin
              errors++;
              $display("FAIL frame_parity cyc=%0d got %b, want %b", cyc, dec_par, ^want);
            end
`endif
          end
          dec_busy = 0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic put(input logic s, input logic [7:0] d, input logic r);
    bus.send    = s;
    bus.data_in = d;
    reset       = r;
  endtask

  initial begin
    put(1'b0, 8'h00, 1'b1);
    step(2);
    put(1'b0, 8'h00, 1'b0);
    step(20);

    // Single frame 0x55.
    put(1'b1, 8'h55, 1'b0); step(1);
    put(1'b0, 8'h00, 1'b0); step(FRAME + 6);

    // Request mid-frame is ignored.
    put(1'b1, 8'hA5, 1'b0); step(1);
    put(1'b0, 8'hA5, 1'b0); step(10);
    put(1'b1, 8'h3C, 1'b0); step(1);
    put(1'b0, 8'h00, 1'b0); step(FRAME);

    // Back-to-back with send held; new data lands on the done edge.
    done_cyc.delete();
    put(1'b1, 8'h0F, 1'b0); step(FRAME - 2);
    put(1'b1, 8'hF0, 1'b0); step(3);
    put(1'b0, 8'h00, 1'b0); step(FRAME + 4);
    checks++;
    if (done_cyc.size() < 2 || done_cyc[1] - done_cyc[0] != FRAME) begin
      errors++;
      $display("FAIL b2b_spacing got %0d dones spacing %0d, want 2 dones spacing %0d",
               done_cyc.size(), (done_cyc.size() >= 2) ? done_cyc[1] - done_cyc[0] : -1, FRAME);
    end

    // Reset during data bit 3 of 0x00, then a clean 0xFF frame.
    put(1'b1, 8'h00, 1'b0); step(1);
    put(1'b0, 8'h00, 1'b0); step(CPB + 3 * CPB + 1);
    put(1'b0, 8'h00, 1'b1); step(1);
    put(1'b1, 8'hFF, 1'b0); step(1);
    put(1'b0, 8'h00, 1'b0); step(FRAME + 4);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      put(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 399) == 0));
      step(1);
    end

    put(1'b0, 8'h00, 1'b0);
    step(FRAME + 10);
    checks++;
    if (byte_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d frames outstanding, want 0", byte_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
